// File: rtl/counter_monitor_if.sv
// Bundle between a 4-bit counter under observation and its monitor.
// The master side drives the counter's inputs and outputs as observed;
// the slave side (the monitor) returns its prediction and health status.
interface counter_monitor_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic [1:0]       mode;
    logic [3:0]       D;
    logic [3:0]       Q;
    logic             rco;
    logic             load;
    logic [3:0]       exp_Q;
    logic             locked;
    logic             fail;
    logic             err;
    logic [2:0]       err_field;
    logic [CNT_W-1:0] err_count;

    modport master (
        output enable, mode, D, Q, rco, load,
        input  exp_Q, locked, fail, err, err_field, err_count
    );

    modport slave (
        input  enable, mode, D, Q, rco, load,
        output exp_Q, locked, fail, err, err_field, err_count
    );
endinterface

// File: rtl/counter_monitor.sv
// Counter monitor: predicts the next count/rco/load of a 4-bit multi-mode
// counter from its inputs, compares the observed outputs against that
// prediction while locked, and drops to a fail state after ERR_LIMIT
// consecutive mismatches. A parallel load (enable=1, mode=11) re-arms it.
module counter_monitor #(
    parameter int ERR_LIMIT = 4,
    parameter int CNT_W     = 8
) (
    input logic              clk,
    input logic              reset,
    counter_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAIL  = 2'd2
    } state_t;

    state_t           state_reg,     state_next;
    logic [3:0]       exp_q_reg,     exp_q_next;
    logic             exp_rco_reg,   exp_rco_next;
    logic             exp_load_reg,  exp_load_next;
    logic             err_reg,       err_next;
    logic [2:0]       err_field_reg, err_field_next;
    logic [CNT_W-1:0] err_count_reg, err_count_next;
    logic [3:0]       consec_reg,    consec_next;
    logic [2:0]       diff;
    logic             rearm;

    // Reference model of the counter, advanced from the current prediction.
    always_comb begin
        exp_q_next    = exp_q_reg;
        exp_rco_next  = 1'b0;
        exp_load_next = 1'b0;
        if (bus.enable) begin
            case (bus.mode)
                2'b00: begin
                    exp_q_next   = exp_q_reg + 4'd1;
                    exp_rco_next = (exp_q_reg == 4'd15);
                end
                2'b01: begin
                    exp_q_next   = exp_q_reg - 4'd1;
                    exp_rco_next = (exp_q_reg == 4'd0);
                end
                2'b10: begin
                    exp_q_next   = exp_q_reg - 4'd3;
                    exp_rco_next = (exp_q_reg < 4'd3);
                end
                default: begin
                    exp_q_next    = bus.D;
                    exp_load_next = 1'b1;
                end
            endcase
        end
    end

    // Check observed outputs against the held prediction and choose next state.
    // Case-inequality makes an unknown observed bit count as a mismatch.
    always_comb begin
        state_next     = state_reg;
        err_next       = 1'b0;
        err_field_next = err_field_reg;
        err_count_next = err_count_reg;
        consec_next    = consec_reg;
        rearm          = bus.enable && (bus.mode == 2'b11);
        diff           = {(bus.Q !== exp_q_reg),
                          (bus.rco !== exp_rco_reg),
                          (bus.load !== exp_load_reg)};
        if (state_reg == TRACK) begin
            if (|diff) begin
                err_next       = 1'b1;
                err_field_next = diff;
                if (err_count_reg != {CNT_W{1'b1}}) begin
                    err_count_next = err_count_reg + 1'b1;
                end
                consec_next = consec_reg + 4'd1;
                if (consec_next == 4'(ERR_LIMIT)) begin
                    state_next = FAIL;
                end
            end else begin
                consec_next = 4'd0;
            end
        end
        // A load re-arms the monitor and wins over a simultaneous drop to FAIL;
        // the failing check above has already been recorded.
        if (rearm) begin
            state_next  = TRACK;
            consec_next = 4'd0;
        end
    end

    // State and prediction registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SYNC;
            exp_q_reg     <= 4'd0;
            exp_rco_reg   <= 1'b0;
            exp_load_reg  <= 1'b0;
            err_reg       <= 1'b0;
            err_field_reg <= 3'b000;
            err_count_reg <= '0;
            consec_reg    <= 4'd0;
        end else begin
            state_reg     <= state_next;
            exp_q_reg     <= exp_q_next;
            exp_rco_reg   <= exp_rco_next;
            exp_load_reg  <= exp_load_next;
            err_reg       <= err_next;
            err_field_reg <= err_field_next;
            err_count_reg <= err_count_next;
            consec_reg    <= consec_next;
        end
    end

    assign bus.exp_Q     = exp_q_reg;
    assign bus.locked    = (state_reg == TRACK);
    assign bus.fail      = (state_reg == FAIL);
    assign bus.err       = err_reg;
    assign bus.err_field = err_field_reg;
    assign bus.err_count = err_count_reg;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed testbench for counter_monitor. A behavioural counter produces the
// observed Q/rco/load; per-bit corruption flags inject faults. All expected
// monitor outputs are hand-computed constants.
module tb_counter_monitor;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic corrupt_q = 1'b0;
    logic corrupt_rco = 1'b0;
    logic corrupt_load = 1'b0;
    logic [3:0] ctr_q;
    logic ctr_rco;
    logic ctr_load;
    int n_cmp = 0;
    int n_bad = 0;

    counter_monitor_if #(.CNT_W(8)) bus ();

    counter_monitor #(.ERR_LIMIT(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural counter standing in for the device being observed.
    always @(posedge clk) begin
        if (reset) begin
            ctr_q <= 4'd0; ctr_rco <= 1'b0; ctr_load <= 1'b0;
        end else if (!bus.enable) begin
            ctr_rco <= 1'b0; ctr_load <= 1'b0;
        end else begin
            case (bus.mode)
                2'b00: begin ctr_q <= ctr_q + 4'd1; ctr_rco <= (ctr_q == 4'd15); ctr_load <= 1'b0; end
                2'b01: begin ctr_q <= ctr_q - 4'd1; ctr_rco <= (ctr_q == 4'd0); ctr_load <= 1'b0; end
                2'b10: begin ctr_q <= ctr_q - 4'd3; ctr_rco <= (ctr_q < 4'd3); ctr_load <= 1'b0; end
                default: begin ctr_q <= bus.D; ctr_rco <= 1'b0; ctr_load <= 1'b1; end
            endcase
        end
    end

    assign bus.Q    = ctr_q ^ {4{corrupt_q}};
    assign bus.rco  = ctr_rco ^ corrupt_rco;
    assign bus.load = ctr_load ^ corrupt_load;

    task automatic drive(input logic en, input logic [1:0] md, input logic [3:0] d);
        bus.enable = en;
        bus.mode   = md;
        bus.D      = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b en=%b mode=%b D=%0d Q=%0d exp_Q=%0d locked=%b fail=%b err=%b field=%b count=%0d",
                 $time, reset, bus.enable, bus.mode, bus.D, bus.Q, bus.exp_Q,
                 bus.locked, bus.fail, bus.err, bus.err_field, bus.err_count);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 2'b00, 4'd0);
        step();
        step();
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.fail !== 1'b0) begin n_bad++; $display("FAIL reset_fail: got %b want 0", bus.fail); end
        n_cmp++; if (bus.exp_Q !== 4'd0) begin n_bad++; $display("FAIL reset_exp_q: got %0d want 0", bus.exp_Q); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        n_cmp++; if (bus.err_count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.err_count); end
        n_cmp++; if (bus.err_field !== 3'b000) begin n_bad++; $display("FAIL reset_field: got %b want 000", bus.err_field); end
        reset = 1'b0;
        step();
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL sync_hold_locked: got %b want 0", bus.locked); end
    endtask

    task automatic test_lock();
        drive(1'b1, 2'b11, 4'd9);
        step();
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL lock_locked: got %b want 1", bus.locked); end
        n_cmp++; if (bus.exp_Q !== 4'd9) begin n_bad++; $display("FAIL lock_exp_q: got %0d want 9", bus.exp_Q); end
        drive(1'b1, 2'b11, 4'd14);
        step();
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL lock_err: got %b want 0", bus.err); end
        n_cmp++; if (bus.exp_Q !== 4'd14) begin n_bad++; $display("FAIL lock_reload: got %0d want 14", bus.exp_Q); end
    endtask

    task automatic test_count_up();
        logic [3:0] want [3];
        want[0] = 4'd15; want[1] = 4'd0; want[2] = 4'd1;
        drive(1'b1, 2'b00, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.exp_Q !== want[i]) begin n_bad++; $display("FAIL up_exp_q[%0d]: got %0d want %0d", i, bus.exp_Q, want[i]); end
            n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL up_err[%0d]: got %b want 0", i, bus.err); end
        end
        n_cmp++; if (bus.err_count !== 8'd0) begin n_bad++; $display("FAIL up_count: got %0d want 0", bus.err_count); end
    endtask

    task automatic test_sub3();
        drive(1'b1, 2'b11, 4'd1);
        step();
        drive(1'b1, 2'b10, 4'd0);
        step();
        n_cmp++; if (bus.exp_Q !== 4'd14) begin n_bad++; $display("FAIL sub3_exp_q: got %0d want 14", bus.exp_Q); end
        drive(1'b0, 2'b10, 4'd0);
        step();
        n_cmp++; if (bus.exp_Q !== 4'd14) begin n_bad++; $display("FAIL hold_exp_q: got %0d want 14", bus.exp_Q); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL sub3_rco_err: got %b want 0", bus.err); end
        step();
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL hold_rco_err: got %b want 0", bus.err); end
    endtask

    task automatic test_q_error();
        corrupt_q = 1'b1;
        step();
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL qerr_err: got %b want 1", bus.err); end
        n_cmp++; if (bus.err_field !== 3'b100) begin n_bad++; $display("FAIL qerr_field: got %b want 100", bus.err_field); end
        n_cmp++; if (bus.err_count !== 8'd1) begin n_bad++; $display("FAIL qerr_count: got %0d want 1", bus.err_count); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL qerr_locked: got %b want 1", bus.locked); end
        corrupt_q = 1'b0;
        step();
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL qerr_pulse: got %b want 0", bus.err); end
        n_cmp++; if (bus.err_field !== 3'b100) begin n_bad++; $display("FAIL qerr_field_hold: got %b want 100", bus.err_field); end
    endtask

    task automatic test_field_bits();
        corrupt_rco = 1'b1;
        step();
        n_cmp++; if (bus.err_field !== 3'b010) begin n_bad++; $display("FAIL rco_field: got %b want 010", bus.err_field); end
        n_cmp++; if (bus.err_count !== 8'd2) begin n_bad++; $display("FAIL rco_count: got %0d want 2", bus.err_count); end
        corrupt_rco = 1'b0;
        corrupt_load = 1'b1;
        step();
        n_cmp++; if (bus.err_field !== 3'b001) begin n_bad++; $display("FAIL load_field: got %b want 001", bus.err_field); end
        n_cmp++; if (bus.err_count !== 8'd3) begin n_bad++; $display("FAIL load_count: got %0d want 3", bus.err_count); end
        corrupt_load = 1'b0;
        step();
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL field_locked: got %b want 1", bus.locked); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL field_err_clear: got %b want 0", bus.err); end
    endtask

    task automatic test_fail();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b1, 2'b11, 4'd6);
        step();
        drive(1'b0, 2'b00, 4'd0);
        corrupt_q = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL fail_pre_locked[%0d]: got %b want 1", i, bus.locked); end
            n_cmp++; if (bus.err_count !== 8'(i)) begin n_bad++; $display("FAIL fail_pre_count[%0d]: got %0d want %0d", i, bus.err_count, i); end
        end
        step();
        n_cmp++; if (bus.fail !== 1'b1) begin n_bad++; $display("FAIL fail_fail: got %b want 1", bus.fail); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL fail_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.err_count !== 8'd4) begin n_bad++; $display("FAIL fail_count: got %0d want 4", bus.err_count); end
        step();
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL fail_no_check: got %b want 0", bus.err); end
        n_cmp++; if (bus.fail !== 1'b1) begin n_bad++; $display("FAIL fail_stays: got %b want 1", bus.fail); end
        corrupt_q = 1'b0;
        drive(1'b1, 2'b11, 4'd3);
        step();
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL rearm_locked: got %b want 1", bus.locked); end
        n_cmp++; if (bus.fail !== 1'b0) begin n_bad++; $display("FAIL rearm_fail: got %b want 0", bus.fail); end
        n_cmp++; if (bus.exp_Q !== 4'd3) begin n_bad++; $display("FAIL rearm_exp_q: got %0d want 3", bus.exp_Q); end
        n_cmp++; if (bus.err_count !== 8'd4) begin n_bad++; $display("FAIL rearm_count: got %0d want 4", bus.err_count); end
    endtask

    task automatic test_reset_mid_track();
        drive(1'b0, 2'b00, 4'd0);
        corrupt_q = 1'b1;
        step();
        n_cmp++; if (bus.err_count !== 8'd5) begin n_bad++; $display("FAIL mid_count5: got %0d want 5", bus.err_count); end
        corrupt_q = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL mid_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.err_count !== 8'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", bus.err_count); end
        n_cmp++; if (bus.exp_Q !== 4'd0) begin n_bad++; $display("FAIL mid_exp_q: got %0d want 0", bus.exp_Q); end
        n_cmp++; if (bus.err_field !== 3'b000) begin n_bad++; $display("FAIL mid_field: got %b want 000", bus.err_field); end
    endtask

    task automatic test_rearm_priority();
        drive(1'b1, 2'b11, 4'd2);
        step();
        drive(1'b0, 2'b00, 4'd0);
        corrupt_q = 1'b1;
        step(); step(); step();
        drive(1'b1, 2'b11, 4'd5);
        step();
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL prio_locked: got %b want 1", bus.locked); end
        n_cmp++; if (bus.fail !== 1'b0) begin n_bad++; $display("FAIL prio_fail: got %b want 0", bus.fail); end
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL prio_err: got %b want 1", bus.err); end
        n_cmp++; if (bus.err_count !== 8'd4) begin n_bad++; $display("FAIL prio_count: got %0d want 4", bus.err_count); end
        n_cmp++; if (bus.exp_Q !== 4'd5) begin n_bad++; $display("FAIL prio_exp_q: got %0d want 5", bus.exp_Q); end
        corrupt_q = 1'b0;
        drive(1'b0, 2'b00, 4'd0);
        step();
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL prio_pass: got %b want 0", bus.err); end
        corrupt_q = 1'b1;
        step();
        corrupt_q = 1'b0;
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL prio_consec_cleared: got %b want 1", bus.locked); end
        n_cmp++; if (bus.err_count !== 8'd5) begin n_bad++; $display("FAIL prio_count5: got %0d want 5", bus.err_count); end
    endtask

    task automatic test_saturate();
        corrupt_q = 1'b1;
        drive(1'b1, 2'b11, 4'd7);
        for (int i = 0; i < 260; i++) step();
        n_cmp++; if (bus.err_count !== 8'd255) begin n_bad++; $display("FAIL sat_count: got %0d want 255", bus.err_count); end
        step();
        n_cmp++; if (bus.err_count !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d want 255", bus.err_count); end
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL sat_err: got %b want 1", bus.err); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL sat_locked: got %b want 1", bus.locked); end
        corrupt_q = 1'b0;
    endtask

    initial begin
        drive(1'b0, 2'b00, 4'd0);
        test_reset();
        test_lock();
        test_count_up();
        test_sub3();
        test_q_error();
        test_field_bits();
        test_fail();
        test_reset_mid_track();
        test_rearm_priority();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
